// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  localparam int unsigned DEFAULT_MAX_WAIT = 255;

  // One MEM/WB slot.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] data;
  } memwb_t;

  localparam memwb_t MEMWB_RESET  = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: synchronous reset, bubble insertion.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   i_load_bubble,
  input  memwb_t i_next,
  output memwb_t o_q
);

  memwb_t r_q;

  // Load the next slot every cycle; a bubble overrides the incoming value.
  always_ff @(posedge clk_i) begin
    if (rst_i)              r_q <= MEMWB_RESET;
    else if (i_load_bubble) r_q <= MEMWB_BUBBLE;
    else                    r_q <= i_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack handshake with timeout, upstream stall,
// misalignment drop and MEM/WB register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic        memtoreg_i,
  input  logic        regwrite_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] write_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic        wb_regwrite_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic              r_memtoreg;
  logic              r_regwrite;
  logic [4:0]        r_rd;
  logic              r_misalign;
  logic              r_timeout;

  logic              w_mem_op;
  logic              w_misaligned;
  logic              w_issue;
  logic              w_misalign_evt;
  logic              w_last;
  logic              w_ack_exit;
  logic              w_timeout_exit;
  logic              w_bubble;
  memwb_t            w_wb_next;
  memwb_t            w_wb_q;

  // Decode the current slot, stall and the next MEM/WB value.
  always_comb begin
    w_mem_op       = memread_i | memwrite_i;
    w_misaligned   = |(alu_result_i[1:0] & WORD_ALIGN_MASK);
    w_issue        = (r_state == IDLE) & valid_i & w_mem_op & ~w_misaligned;
    w_misalign_evt = (r_state == IDLE) & valid_i & w_mem_op & w_misaligned;
    // Counter is cleared on entry, so the MAX_WAIT-th WAIT cycle sees MAX_WAIT-1.
    w_last         = (r_cnt == CNT_W'(MAX_WAIT - 1));
    w_ack_exit     = (r_state == WAIT) & mem_ack_i;
    w_timeout_exit = (r_state == WAIT) & ~mem_ack_i & w_last;
    stall_o        = w_issue | ((r_state == WAIT) & ~mem_ack_i & ~w_last);

    w_bubble  = 1'b1;
    w_wb_next = MEMWB_BUBBLE;
    if ((r_state == IDLE) && valid_i && !w_mem_op) begin
      w_bubble           = 1'b0;
      w_wb_next.valid    = 1'b1;
      w_wb_next.regwrite = regwrite_i;
      w_wb_next.rd       = rd_addr_i;
      w_wb_next.data     = alu_result_i;
    end else if (w_misalign_evt || w_timeout_exit) begin
      w_bubble        = 1'b0;
      w_wb_next.valid = 1'b1;
    end else if (w_ack_exit) begin
      w_bubble           = 1'b0;
      w_wb_next.valid    = 1'b1;
      w_wb_next.regwrite = r_regwrite;
      w_wb_next.rd       = r_rd;
      w_wb_next.data     = r_memtoreg ? mem_rdata_i : r_addr;
    end
  end

  // Handshake FSM, wait counter, latched access and event pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_misalign <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_misalign <= w_misalign_evt;
      r_timeout  <= w_timeout_exit;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state    <= WAIT;
            r_cnt      <= '0;
            r_addr     <= alu_result_i;
            r_wdata    <= write_data_i;
            r_we       <= memwrite_i;
            // A combined read/write is a store: never write back memory data.
            r_memtoreg <= memtoreg_i & ~memwrite_i;
            r_regwrite <= regwrite_i;
            r_rd       <= rd_addr_i;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (mem_ack_i || w_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_load_bubble (w_bubble),
    .i_next        (w_wb_next),
    .o_q           (w_wb_q)
  );

  assign mem_req_o     = (r_state == WAIT);
  assign mem_we_o      = r_we;
  assign mem_addr_o    = r_addr;
  assign mem_wdata_o   = r_wdata;
  assign wb_valid_o    = w_wb_q.valid;
  assign wb_regwrite_o = w_wb_q.regwrite;
  assign wb_rd_addr_o  = w_wb_q.rd;
  assign wb_data_o     = w_wb_q.data;
  assign misalign_o    = r_misalign;
  assign timeout_o     = r_timeout;

endmodule
